eth_tx_arbiter: RTL and testbench

Shares the single RGMII TX byte stream between the three frame builders: ARP, ICMP and UDP. Each builder presents a complete frame as a VALID/READY/LAST byte stream. The arbiter grants one whole frame at a time, using round-robin, and enforces an inter-frame gap before the next grant. It sits between the TX_* builders and the RGMII TX MAC.

---
 rtl/eth_tx_arbiter_pkg.sv | 23 ++
 rtl/eth_tx_arbiter_rr_pick3.sv | 43 ++++
 rtl/eth_tx_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arbiter_pkg.sv
// eth_tx_arbiter_pkg
//   Shared definitions for the Ethernet TX arbiter: source indices in their
//   fixed order, the "no owner" grant code, the FSM state encoding, and a
//   helper that steps a 3-entry round-robin index.
package eth_tx_arbiter_pkg;

    localparam logic [1:0] SRC_ARP    = 2'd0;
    localparam logic [1:0] SRC_ICMP   = 2'd1;
    localparam logic [1:0] SRC_UDP    = 2'd2;
    localparam logic [1:0] GRANT_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_GAP     = 2'd2
    } state_e;

    // Next index in cyclic order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= SRC_UDP) ? SRC_ARP : idx + 2'd1;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_pick3.sv
// rr_pick3
//   Combinational round-robin picker for exactly three requesters.
//   Returns the first requester at or after the pointer, in cyclic order.
//   Ports:
//     req    [2:0] request vector (bit i = requester i)
//     ptr    [1:0] highest-priority index this round (3 is treated as 0)
//     winner [1:0] chosen requester, GRANT_NONE when nobody requests
//     hit          any requester present
module rr_pick3
    import eth_tx_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       hit
);

    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;

    // Evaluate lowest priority first so the highest-priority hit lands last.
    always_comb begin
        c0     = (ptr == GRANT_NONE) ? SRC_ARP : ptr;
        c1     = rr_next(c0);
        c2     = rr_next(c1);
        winner = GRANT_NONE;
        hit    = 1'b0;
        if (req[c2]) begin
            winner = c2;
            hit    = 1'b1;
        end
        if (req[c1]) begin
            winner = c1;
            hit    = 1'b1;
        end
        if (req[c0]) begin
            winner = c0;
            hit    = 1'b1;
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
//   Shares one RGMII TX byte stream between the ARP, ICMP and UDP frame
//   builders. Whole frames are granted round-robin; after each frame's last
//   beat an inter-frame gap of IFG_CYCLES idle cycles is enforced.
//   The data path is a zero-latency mux on the registered grant.
//   Ports:
//     CLK_125M, SYS_RST_N            clock, async active-low reset
//     {ARP,ICMP,UDP}_DATA/VALID/LAST  builder byte streams (in)
//     {ARP,ICMP,UDP}_READY            builder back-pressure (out)
//     TX_DATA/VALID/LAST, TX_READY    stream to the MAC
//     GRANT                           current owner 0/1/2, 3 = none
//     BUSY                            high while forwarding or in the gap
//   Optional build macro ETH_TX_ARB_STATS_EN adds ARP_FRAMES, ICMP_FRAMES,
//   UDP_FRAMES: 16-bit wrapping counts of completed frames per source.
module eth_tx_arbiter
    import eth_tx_arbiter_pkg::*;
#(
    parameter int N_SRC      = 3,
    parameter int IFG_CYCLES = 12,
    parameter int IFG_W      = 4
) (
    input  logic        CLK_125M,
    input  logic        SYS_RST_N,
    input  logic [7:0]  ARP_DATA,
    input  logic        ARP_VALID,
    input  logic        ARP_LAST,
    output logic        ARP_READY,
    input  logic [7:0]  ICMP_DATA,
    input  logic        ICMP_VALID,
    input  logic        ICMP_LAST,
    output logic        ICMP_READY,
    input  logic [7:0]  UDP_DATA,
    input  logic        UDP_VALID,
    input  logic        UDP_LAST,
    output logic        UDP_READY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    output logic        TX_LAST,
    input  logic        TX_READY,
    output logic [1:0]  GRANT,
    output logic        BUSY
`ifdef ETH_TX_ARB_STATS_EN
    ,
    output logic [15:0] ARP_FRAMES,
    output logic [15:0] ICMP_FRAMES,
    output logic [15:0] UDP_FRAMES
`endif
);

    localparam logic [IFG_W-1:0] GAP_LAST = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    logic [N_SRC-1:0][7:0] src_data;
    logic [N_SRC-1:0]      src_valid;
    logic [N_SRC-1:0]      src_last;
    logic [N_SRC-1:0]      src_ready;

    assign src_data  = {UDP_DATA,  ICMP_DATA,  ARP_DATA};
    assign src_valid = {UDP_VALID, ICMP_VALID, ARP_VALID};
    assign src_last  = {UDP_LAST,  ICMP_LAST,  ARP_LAST};

    assign ARP_READY  = src_ready[SRC_ARP];
    assign ICMP_READY = src_ready[SRC_ICMP];
    assign UDP_READY  = src_ready[SRC_UDP];

    state_e            state_q,   state_d;
    logic [1:0]        grant_q,   grant_d;
    logic [1:0]        rr_ptr_q,  rr_ptr_d;
    logic [IFG_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic [1:0] pick_winner;
    logic       pick_hit;
    logic       frame_done;

    rr_pick3 u_pick (
        .req    (src_valid),
        .ptr    (rr_ptr_q),
        .winner (pick_winner),
        .hit    (pick_hit)
    );

    // State register
    always_ff @(posedge CLK_125M or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q   <= ST_IDLE;
            grant_q   <= GRANT_NONE;
            rr_ptr_q  <= SRC_ARP;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Last beat of the owned frame is accepted by the MAC this cycle.
    assign frame_done = (state_q == ST_FORWARD) && TX_VALID && TX_READY && TX_LAST;

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_hit) begin
                    grant_d = pick_winner;
                    state_d = ST_FORWARD;
                end
            end
            ST_FORWARD: begin
                // Other requests are ignored until the owned frame ends.
                if (frame_done) begin
                    rr_ptr_d  = rr_next(grant_q);
                    grant_d   = GRANT_NONE;
                    gap_cnt_d = '0;
                    state_d   = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GRANT_NONE;
            end
        endcase
    end

    // Output logic: mux on the registered grant, quiet outside FORWARD.
    always_comb begin
        TX_DATA   = 8'h00;
        TX_VALID  = 1'b0;
        TX_LAST   = 1'b0;
        src_ready = '0;
        if (state_q == ST_FORWARD) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (grant_q == 2'(i)) begin
                    TX_DATA      = src_data[i];
                    TX_VALID     = src_valid[i];
                    TX_LAST      = src_last[i];
                    src_ready[i] = TX_READY;
                end
            end
        end
    end

    assign GRANT = grant_q;
    assign BUSY  = (state_q != ST_IDLE);

`ifdef ETH_TX_ARB_STATS_EN
    logic [N_SRC-1:0][15:0] frames_q, frames_d;

    always_comb begin
        frames_d = frames_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (frame_done && (grant_q == 2'(i))) begin
                frames_d[i] = frames_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK_125M or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            frames_q <= '0;
        end else begin
            frames_q <= frames_d;
        end
    end

    assign ARP_FRAMES  = frames_q[SRC_ARP];
    assign ICMP_FRAMES = frames_q[SRC_ICMP];
    assign UDP_FRAMES  = frames_q[SRC_UDP];
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter
//   Directed bench for eth_tx_arbiter. Each source is a simple builder model
//   that walks through a frame of known bytes, advancing on VALID && READY.
//   Bytes seen on TX are captured and checked against the known pattern.
module tb_eth_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data [3];
    logic [2:0] s_valid;
    logic [2:0] s_last;
    logic [2:0] s_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic [1:0] grant;
    logic       busy;
`ifdef ETH_TX_ARB_STATS_EN
    logic [15:0] arp_frames, icmp_frames, udp_frames;
`endif

    always #4 clk = ~clk;

    eth_tx_arbiter #(.N_SRC(3), .IFG_CYCLES(12), .IFG_W(4)) dut (
        .CLK_125M   (clk),
        .SYS_RST_N  (rst_n),
        .ARP_DATA   (s_data[0]),
        .ARP_VALID  (s_valid[0]),
        .ARP_LAST   (s_last[0]),
        .ARP_READY  (s_ready[0]),
        .ICMP_DATA  (s_data[1]),
        .ICMP_VALID (s_valid[1]),
        .ICMP_LAST  (s_last[1]),
        .ICMP_READY (s_ready[1]),
        .UDP_DATA   (s_data[2]),
        .UDP_VALID  (s_valid[2]),
        .UDP_LAST   (s_last[2]),
        .UDP_READY  (s_ready[2]),
        .TX_DATA    (tx_data),
        .TX_VALID   (tx_valid),
        .TX_LAST    (tx_last),
        .TX_READY   (tx_ready),
        .GRANT      (grant),
        .BUSY       (busy)
`ifdef ETH_TX_ARB_STATS_EN
        ,
        .ARP_FRAMES  (arp_frames),
        .ICMP_FRAMES (icmp_frames),
        .UDP_FRAMES  (udp_frames)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int viol     = 0;

    int src_len [3];
    int src_idx [3];
    bit src_active [3];
    bit src_pause  [3];

    logic [7:0] rx_data [$];
    logic       rx_last [$];
    logic [1:0] rx_src  [$];

    function automatic logic [7:0] exp_byte(input int s, input int i);
        return 8'((s * 77 + i * 5 + 3) % 256);
    endfunction

    task automatic drive();
        for (int s = 0; s < 3; s++) begin
            s_valid[s] = src_active[s] && !src_pause[s];
            s_data[s]  = src_active[s] ? exp_byte(s, src_idx[s]) : 8'h00;
            s_last[s]  = src_active[s] && (src_idx[s] == src_len[s] - 1);
        end
    endtask

    task automatic start_frame(input int s, input int len);
        src_active[s] = 1'b1;
        src_pause[s]  = 1'b0;
        src_idx[s]    = 0;
        src_len[s]    = len;
        drive();
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_last.delete();
        rx_src.delete();
        viol = 0;
    endtask

    // One clock: observe at the falling edge, update the builders after the
    // rising edge. Also tallies READY/VALID routing errors into viol.
    task automatic tick();
        logic [2:0] xfer;
        @(negedge clk);
        xfer = s_valid & s_ready;
        if (tx_valid && tx_ready) begin
            rx_data.push_back(tx_data);
            rx_last.push_back(tx_last);
            rx_src.push_back(grant);
        end
        for (int s = 0; s < 3; s++)
            if (s_ready[s] !== ((grant == 2'(s)) ? tx_ready : 1'b0)) viol++;
        if (grant != 2'd3 && tx_valid !== s_valid[grant]) viol++;
        if (grant == 2'd3 && (tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 8'h00)) viol++;
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            if (xfer[s]) begin
                if (src_idx[s] == src_len[s] - 1) src_active[s] = 1'b0;
                else src_idx[s]++;
            end
        end
        drive();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (rx_data.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
    endtask

    // Mismatched beats of one frame in the capture queue (missing beats count).
    function automatic int frame_errs(input int start, input int s, input int len);
        int e = 0;
        for (int k = 0; k < len; k++) begin
            if (start + k >= rx_data.size()) e++;
            else if (rx_data[start+k] !== exp_byte(s, k) || rx_src[start+k] !== 2'(s) ||
                     rx_last[start+k] !== (k == len - 1)) e++;
        end
        return e;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        tx_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            src_active[s] = 1'b0;
            src_pause[s]  = 1'b0;
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_rx();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tx_ready = 1'b1;
        for (int s = 0; s < 3; s++) start_frame(s, 4);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (grant !== 2'd3) begin failures++; $display("FAIL reset_grant: got %0d want 3", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (tx_valid !== 1'b0 || tx_last !== 1'b0) begin failures++; $display("FAIL reset_txvl: got %0b%0b want 00", tx_valid, tx_last); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_txdata: got %02h want 00", tx_data); end
        checks++; if (s_ready !== 3'b000) begin failures++; $display("FAIL reset_ready: got %03b want 000", s_ready); end
        for (int s = 0; s < 3; s++) src_active[s] = 1'b0;
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_rx();
        tick();
        checks++; if (grant !== 2'd3 || busy !== 1'b0) begin failures++; $display("FAIL idle_no_req: grant %0d busy %0b want 3/0", grant, busy); end
    endtask

    task automatic test_single_arp();
        int n;
        clear_rx();
        start_frame(0, 42);
        tick();
        checks++; if (grant !== 2'd0 || busy !== 1'b1) begin failures++; $display("FAIL arp_grant: grant %0d busy %0b want 0/1", grant, busy); end
        wait_beats(42, 200);
        checks++; if (frame_errs(0, 0, 42) != 0) begin failures++; $display("FAIL arp_frame: %0d bad beats want 0", frame_errs(0, 0, 42)); end
        checks++; if (grant !== 2'd3 || busy !== 1'b1) begin failures++; $display("FAIL arp_end: grant %0d busy %0b want 3/1", grant, busy); end
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        checks++; if (n != 12) begin failures++; $display("FAIL arp_gap: %0d cycles want 12", n); end
        checks++; if (rx_data.size() != 42 || viol != 0) begin failures++; $display("FAIL arp_quiet: beats %0d viol %0d want 42/0", rx_data.size(), viol); end
    endtask

    task automatic test_icmp_udp();
        int n;
        apply_reset();
        start_frame(1, 20);
        start_frame(2, 15);
        tick();
        checks++; if (grant !== 2'd1) begin failures++; $display("FAIL iu_first: got %0d want 1", grant); end
        wait_beats(20, 100);
        n = 0;
        while (grant !== 2'd2 && n < 50) begin tick(); n++; end
        checks++; if (n != 13) begin failures++; $display("FAIL iu_udp_latency: got %0d want 13", n); end
        wait_beats(35, 100);
        checks++; if (frame_errs(0, 1, 20) + frame_errs(20, 2, 15) != 0) begin failures++; $display("FAIL iu_frames: %0d bad beats want 0", frame_errs(0, 1, 20) + frame_errs(20, 2, 15)); end
        checks++; if (viol != 0) begin failures++; $display("FAIL iu_ready_route: %0d violations want 0", viol); end
        wait_idle(40);
    endtask

    task automatic test_ready_toggle();
        int k = 0;
        clear_rx();
        start_frame(2, 10);
        while (rx_data.size() < 10 && k < 100) begin
            tx_ready = (k % 2 == 0);
            tick();
            k++;
        end
        tx_ready = 1'b1;
        checks++; if (k != 21) begin failures++; $display("FAIL tog_cycles: got %0d want 21", k); end
        checks++; if (frame_errs(0, 2, 10) != 0) begin failures++; $display("FAIL tog_frame: %0d bad beats want 0", frame_errs(0, 2, 10)); end
        checks++; if (viol != 0) begin failures++; $display("FAIL tog_ready_mirror: %0d violations want 0", viol); end
        wait_idle(40);
    endtask

    task automatic test_hold();
        int bad = 0;
        clear_rx();
        start_frame(0, 16);
        wait_beats(5, 50);
        src_pause[0] = 1'b1;
        start_frame(1, 8);
        repeat (5) begin
            tick();
            if (grant !== 2'd0 || s_ready[1] !== 1'b0) bad++;
        end
        checks++; if (bad != 0 || rx_data.size() != 5) begin failures++; $display("FAIL hold_grant: bad %0d beats %0d want 0/5", bad, rx_data.size()); end
        src_pause[0] = 1'b0;
        drive();
        wait_beats(24, 200);
        checks++; if (frame_errs(0, 0, 16) != 0) begin failures++; $display("FAIL hold_arp_frame: %0d bad beats want 0", frame_errs(0, 0, 16)); end
        checks++; if (frame_errs(16, 1, 8) != 0 || viol != 0) begin failures++; $display("FAIL hold_icmp_after: bad %0d viol %0d want 0/0", frame_errs(16, 1, 8), viol); end
        wait_idle(40);
    endtask

    task automatic test_reset_mid();
        clear_rx();
        start_frame(1, 30);
        wait_beats(10, 50);
        rst_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0 || grant !== 2'd3 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_clear: valid %0b grant %0d busy %0b want 0/3/0", tx_valid, grant, busy); end
        checks++; if (s_ready !== 3'b000) begin failures++; $display("FAIL rstmid_ready: got %03b want 000", s_ready); end
        for (int s = 0; s < 3; s++) src_active[s] = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_rx();
        start_frame(0, 6);
        start_frame(2, 6);
        tick();
        checks++; if (grant !== 2'd0) begin failures++; $display("FAIL rstmid_ptr: got %0d want 0", grant); end
        wait_beats(12, 100);
        checks++; if (frame_errs(0, 0, 6) + frame_errs(6, 2, 6) != 0) begin failures++; $display("FAIL rstmid_frames: %0d bad beats want 0", frame_errs(0, 0, 6) + frame_errs(6, 2, 6)); end
        wait_idle(40);
    endtask

    // ARP alone; ICMP+UDP rise while ARP's last beat is on the bus; ARP
    // returns during ICMP. Expected order: ARP, ICMP, UDP, ARP.
    task automatic test_rr();
        int n;
        clear_rx();
        start_frame(0, 4);
        wait_beats(3, 50);
        start_frame(1, 4);
        start_frame(2, 4);
        n = 0;
        while (grant !== 2'd1 && n < 50) begin tick(); n++; end
        checks++; if (n != 14) begin failures++; $display("FAIL rr_late_req: got %0d want 14", n); end
        wait_beats(5, 50);
        start_frame(0, 4);
        wait_beats(16, 300);
        checks++; if (frame_errs(0, 0, 4) + frame_errs(4, 1, 4) + frame_errs(8, 2, 4) + frame_errs(12, 0, 4) != 0) begin
            failures++; $display("FAIL rr_order: %0d bad beats want 0", frame_errs(0, 0, 4) + frame_errs(4, 1, 4) + frame_errs(8, 2, 4) + frame_errs(12, 0, 4));
        end
        wait_idle(40);
    endtask

`ifdef ETH_TX_ARB_STATS_EN
    task automatic test_stats();
        int tot = 0;
        int seq [6] = '{0, 1, 0, 2, 1, 0};
        apply_reset();
        checks++; if (arp_frames !== 16'd0 || icmp_frames !== 16'd0 || udp_frames !== 16'd0) begin failures++; $display("FAIL stats_reset: %0d/%0d/%0d want 0/0/0", arp_frames, icmp_frames, udp_frames); end
        foreach (seq[i]) begin
            start_frame(seq[i], 3);
            tot += 3;
            wait_beats(tot, 100);
            wait_idle(40);
        end
        checks++; if (arp_frames !== 16'd3 || icmp_frames !== 16'd2 || udp_frames !== 16'd1) begin failures++; $display("FAIL stats_count: %0d/%0d/%0d want 3/2/1", arp_frames, icmp_frames, udp_frames); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_arp();
        test_icmp_udp();
        test_ready_toggle();
        test_hold();
        test_reset_mid();
        test_rr();
`ifdef ETH_TX_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
